// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer: controller states,
// instruction field layout and a width helper.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, LOAD, FEED, DRAIN, WRITE, DONE
  } state_t;

  localparam int INSTR_W = 32;
  localparam int K_LSB   = 0;
  localparam int K_W     = 8;
  localparam int T_LSB   = 8;

  // Never returns less than 1 so degenerate sizes still give a legal vector.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/skew_feeder.sv
// Dual K-deep operand buffers for A and B, read back as skewed wavefronts:
// lane i carries buffer row (beat - i) so each lane lags its neighbour by one beat.
module skew_feeder
  import systolic_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int MAXK   = 32,
  parameter int CW     = 6
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_row,
  input  logic [N*DATA_W-1:0] wr_a,
  input  logic [N*DATA_W-1:0] wr_b,
  input  logic                feed_en,
  input  logic [CW-1:0]       beat,
  input  logic [K_W-1:0]      k,
  output logic [N*DATA_W-1:0] north,
  output logic [N*DATA_W-1:0] west
);

  localparam int RW = clog2(MAXK);

  logic [DATA_W-1:0] buf_a [MAXK][N];
  logic [DATA_W-1:0] buf_b [MAXK][N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < N; i++) begin
        buf_a[RW'(wr_row)][i] <= wr_a[i*DATA_W +: DATA_W];
        buf_b[RW'(wr_row)][i] <= wr_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // Lanes outside their K-row window read as zero, which forms the skew ramps.
  always_comb begin
    int rel;
    north = '0;
    west  = '0;
    rel   = 0;
    for (int i = 0; i < N; i++) begin
      rel = int'(beat) - i;
      if (feed_en && rel >= 0 && rel < int'(k)) begin
        north[i*DATA_W +: DATA_W] = buf_a[RW'(rel)][i];
        west[i*DATA_W +: DATA_W]  = buf_b[RW'(rel)][i];
      end
    end
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Program sequencer for an N x N systolic multiply array: fetch, load tile,
// feed skewed wavefronts, drain, write results back, until a K=0 terminator.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int N         = 4,
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 16,
  parameter int ADDR_W    = 32,
  parameter int MAXK      = 32,
  parameter int DRAIN_CYC = 2*N
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  err,
  output logic [ADDR_W-1:0]     i_addr,
  output logic                  i_rd,
  input  logic [INSTR_W-1:0]    i_data,
  output logic [ADDR_W-1:0]     ab_addr,
  output logic                  ab_rd,
  input  logic [N*DATA_W-1:0]   a_rdata,
  input  logic [N*DATA_W-1:0]   b_rdata,
  output logic [N*DATA_W-1:0]   north,
  output logic [N*DATA_W-1:0]   west,
  output logic                  arr_clr,
  input  logic [N*N*ACC_W-1:0]  result,
  output logic                  o_we,
  output logic [ADDR_W-1:0]     o_addr,
  output logic [N*ACC_W-1:0]    o_wdata
);

  localparam int CW = clog2(MAXK + N);

  state_t                   state, state_nx;
  logic [CW-1:0]            cnt;
  logic [K_W-1:0]           k_q;
  logic [ADDR_W-1:0]        ip, o_ptr, base_q;
  logic                     err_q;
  logic [K_W-1:0]           k_in;
  logic [INSTR_W-T_LSB-1:0] t_in;
  logic                     k_bad, last_load, last_feed, last_drain, last_write;
  logic                     feed_wr;
  logic [CW-1:0]            wr_row;

  assign k_in       = i_data[K_LSB +: K_W];
  assign t_in       = i_data[T_LSB +: INSTR_W-T_LSB];
  assign k_bad      = int'(k_in) > MAXK;
  assign last_load  = (cnt == CW'(k_q));
  assign last_feed  = (int'(cnt) == int'(k_q) + N - 2);
  assign last_drain = (int'(cnt) == DRAIN_CYC - 1);
  assign last_write = (int'(cnt) == N - 1);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ap_start) state_nx = FETCH;
      FETCH:   state_nx = DECODE;
      DECODE: begin
        if (k_in == '0)  state_nx = DONE;
        else if (k_bad)  state_nx = FETCH;
        else             state_nx = LOAD;
      end
      LOAD:    if (last_load)  state_nx = FEED;
      FEED:    if (last_feed)  state_nx = DRAIN;
      DRAIN:   if (last_drain) state_nx = WRITE;
      WRITE:   if (last_write) state_nx = FETCH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // cnt restarts on every state change, so it is the beat/row index within a phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      k_q    <= '0;
      ip     <= '0;
      o_ptr  <= '0;
      base_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state) cnt <= '0;
      else if (state != IDLE) cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          if (ap_start) begin
            ip    <= '0;
            o_ptr <= '0;
            err_q <= 1'b0;
          end
        end
        DECODE: begin
          k_q    <= k_in;
          base_q <= ADDR_W'(t_in) * ADDR_W'(MAXK);
          ip     <= ip + 1'b1;
          if (k_bad) err_q <= 1'b1;
        end
        WRITE: if (last_write) o_ptr <= o_ptr + ADDR_W'(N);
        default: ;
      endcase
    end
  end

  always_comb begin
    i_rd    = 1'b0;
    i_addr  = '0;
    ab_rd   = 1'b0;
    ab_addr = '0;
    arr_clr = 1'b0;
    o_we    = 1'b0;
    o_addr  = '0;
    o_wdata = '0;
    ap_done = 1'b0;
    case (state)
      FETCH: begin
        i_rd   = 1'b1;
        i_addr = ip;
      end
      LOAD: begin
        arr_clr = (cnt == '0);
        if (!last_load) begin
          ab_rd   = 1'b1;
          ab_addr = base_q + ADDR_W'(cnt);
        end
      end
      WRITE: begin
        o_we   = 1'b1;
        o_addr = o_ptr + ADDR_W'(cnt);
        for (int r = 0; r < N; r++)
          if (int'(cnt) == r) o_wdata = result[r*N*ACC_W +: N*ACC_W];
      end
      DONE:    ap_done = 1'b1;
      default: ;
    endcase
  end

  // Read data lags the strobe by a cycle, so LOAD beat c captures row c-1.
  assign feed_wr = (state == LOAD) && (cnt != '0);
  assign wr_row  = cnt - 1'b1;
  assign err     = err_q;

  skew_feeder #(
    .N(N), .DATA_W(DATA_W), .MAXK(MAXK), .CW(CW)
  ) u_feeder (
    .clk     (clk),
    .wr_en   (feed_wr),
    .wr_row  (wr_row),
    .wr_a    (a_rdata),
    .wr_b    (b_rdata),
    .feed_en (state == FEED),
    .beat    (cnt),
    .k       (k_q),
    .north   (north),
    .west    (west)
  );

endmodule
